// File: rtl/disp_scan.sv
// Four-digit multiplexed 7-segment scanner with per-frame input snapshot and anode guard time.
// Leading-zero blanking is compiled in only when DISP_SCAN_LZB_EN is defined.
module disp_scan #(
    parameter int REFRESH_DIV = 50000,
    parameter int GUARD       = 500
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        EN,
    input  logic [15:0] DIGITS,
    input  logic [3:0]  DP_MASK,
    input  logic        BLANK_LZ,
    output logic [3:0]  DIG_OUT,
    output logic        DP_OUT,
    output logic [3:0]  AN,
    output logic        SCAN_TICK
);

    localparam int            CW       = $clog2(REFRESH_DIV);
    localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    idx_q, idx_d;
    logic [15:0]   snap_dig_q, snap_dig_d;
    logic [3:0]    snap_dp_q, snap_dp_d;
    logic [3:0]    dig_out_q, dig_out_d;
    logic          dp_out_q, dp_out_d;
    logic [3:0]    an_q, an_d;
    logic          tick_q, tick_d;
    logic [3:0]    blank_vec;

    // Slot/digit sequencing; the snapshot is refreshed only as a new frame begins.
    always_comb begin
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        snap_dig_d = snap_dig_q;
        snap_dp_d  = snap_dp_q;
        if (EN) begin
            if (cnt_q == CNT_LAST) begin
                cnt_d = '0;
                idx_d = idx_q + 2'd1;
                if (idx_q == 2'd3) begin
                    snap_dig_d = DIGITS;
                    snap_dp_d  = DP_MASK;
                end
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

`ifdef DISP_SCAN_LZB_EN
    logic snap_blz_q, snap_blz_d;

    always_comb begin
        snap_blz_d = snap_blz_q;
        if (EN && cnt_q == CNT_LAST && idx_q == 2'd3) begin
            snap_blz_d = BLANK_LZ;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            snap_blz_q <= 1'b0;
        end else begin
            snap_blz_q <= snap_blz_d;
        end
    end

    // Digit gi is a leading zero when it and every digit to its left are zero.
    genvar gi;
    generate
        for (gi = 1; gi < 4; gi++) begin : g_lz
            assign blank_vec[gi] = snap_blz_d && !snap_dp_d[gi] && (snap_dig_d[15:4*gi] == '0);
        end
    endgenerate
    assign blank_vec[0] = 1'b0;
`else
    logic unused_blank_lz;
    assign unused_blank_lz = BLANK_LZ;
    assign blank_vec       = 4'b0000;
`endif

    // Outputs are computed from the next state so they track the new slot on its first cycle.
    always_comb begin
        dig_out_d = dig_out_q;
        dp_out_d  = dp_out_q;
        an_d      = 4'b1111;
        tick_d    = 1'b0;
        if (EN) begin
            dig_out_d = snap_dig_d[{idx_d, 2'b00} +: 4];
            dp_out_d  = ~snap_dp_d[idx_d];
            tick_d    = (cnt_d == '0);
            if (!(int'(cnt_d) < GUARD) && !blank_vec[idx_d]) begin
                an_d = ~(4'b0001 << idx_d);
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            cnt_q      <= CNT_LAST;
            idx_q      <= 2'd3;
            snap_dig_q <= '0;
            snap_dp_q  <= '0;
            dig_out_q  <= 4'h0;
            dp_out_q   <= 1'b1;
            an_q       <= 4'b1111;
            tick_q     <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            snap_dig_q <= snap_dig_d;
            snap_dp_q  <= snap_dp_d;
            dig_out_q  <= dig_out_d;
            dp_out_q   <= dp_out_d;
            an_q       <= an_d;
            tick_q     <= tick_d;
        end
    end

    assign DIG_OUT   = dig_out_q;
    assign DP_OUT    = dp_out_q;
    assign AN        = an_q;
    assign SCAN_TICK = tick_q;

endmodule

// File: doc/disp_scan.md
DISP_SCAN -- requirements
Module: disp_scan

Interface
REQ-001 SHALL have parameter REFRESH_DIV, default 50000: clock cycles per digit slot; legal range >= 2.
REQ-002 SHALL have parameter GUARD, default 500: anode-off cycles at start of each slot; legal range 0 .. REFRESH_DIV-1.
REQ-003 SHALL have port CLK  input  1  system clock; all state changes on rising edge.
REQ-004 SHALL have port RST_N  input  1  reset; one clock, reset is synchronous and active-low.
REQ-005 SHALL have port EN  input  1  scan enable.
REQ-006 SHALL have port DIGITS  input  16  four BCD nibbles; [3:0] digit 0 (rightmost) .. [15:12] digit 3.
REQ-007 SHALL have port DP_MASK  input  4  active-high decimal-point request per digit.
REQ-008 SHALL have port BLANK_LZ  input  1  leading-zero blanking request.
REQ-009 SHALL have port DIG_OUT  output  4  BCD nibble for the 7-segment decoder.
REQ-010 SHALL have port DP_OUT  output  1  active-low decimal point for the decoder DP input.
REQ-011 SHALL have port AN  output  4  active-low anode selects; bit i drives digit i.
REQ-012 SHALL have port SCAN_TICK  output  1  one-cycle pulse in the first cycle of every slot.

Function
REQ-013 SHALL keep slot counter CNT (0..REFRESH_DIV-1) and digit index IDX (0..3); each edge with EN=1 increments CNT; at CNT=REFRESH_DIV-1, CNT wraps to 0 and IDX advances 0->1->2->3->0.
REQ-014 SHALL drive all outputs from registers; DIG_OUT, DP_OUT, AN and SCAN_TICK reflect the new IDX from the first cycle of its slot.
REQ-015 SHALL capture DIGITS, DP_MASK and BLANK_LZ into a snapshot on the edge where IDX wraps to 0; all outputs in the frame use only the snapshot (no tearing).
REQ-016 SHALL set DIG_OUT = snapshot nibble IDX and DP_OUT = ~snapshot DP_MASK[IDX] for the whole slot.
REQ-017 SHALL hold AN = 4'b1111 for the first GUARD cycles of each slot, then AN = ~(1<<IDX) for the remaining REFRESH_DIV-GUARD cycles, unless the digit is blanked.
REQ-018 SHALL pulse SCAN_TICK high for exactly the first cycle of every slot, REFRESH_DIV cycles apart while EN=1.
REQ-019 SHALL, with EN=0, freeze CNT, IDX and snapshot, force AN = 4'b1111 and SCAN_TICK = 0; re-assertion resumes from the held CNT with no extra tick.
REQ-020 SHALL pass non-BCD nibbles (A..F) through unchanged on DIG_OUT.
REQ-021 SHALL apply GUARD=0 as no blank cycles: AN active for the whole slot.

Reset
REQ-022 SHALL, on an edge with RST_N=0, set CNT=REFRESH_DIV-1, IDX=3, snapshot=0, DIG_OUT=4'h0, DP_OUT=1, AN=4'b1111, SCAN_TICK=0, overriding EN and any slot in progress.
REQ-023 SHALL make the first edge with RST_N=1 and EN=1 start slot 0: snapshot captured, SCAN_TICK=1, DIG_OUT=DIGITS[3:0].

Configuration
REQ-024 SHALL compile leading-zero blanking only when macro DISP_SCAN_LZB_EN is defined.
REQ-025 SHALL, with DISP_SCAN_LZB_EN defined and snapshot BLANK_LZ=1, blank digit i (i=3,2,1; AN bit i held 1 all slot) when snapshot digits 3..i are all zero and DP_MASK[i]=0; digit 0 never blanked.
REQ-026 SHALL, without DISP_SCAN_LZB_EN, ignore BLANK_LZ and never blank a digit outside the guard interval.

Verification
REQ-027 SHALL cover: REFRESH_DIV=4, GUARD=1, DIGITS=16'h1234, DP_MASK=4'b0100, EN=1 -> DIG_OUT 4,3,2,1 repeating; per slot AN 1111 then 3 cycles of 1110/1101/1011/0111; DP_OUT=0 only in digit-2 slot; SCAN_TICK every 4 cycles.
REQ-028 SHALL cover: macro defined, BLANK_LZ=1, DIGITS=16'h0005 -> AN active only in digit-0 slot; DIGITS=16'h0000 -> digit 0 shows 0; DIGITS=16'h0005 with DP_MASK=4'b0010 -> digit 1 shown; macro undefined -> all four digits shown.
REQ-029 SHALL cover: DIGITS changed 16'h1234->16'h9876 during digit-1 slot -> digits 2,3 still show 2,1; next frame shows 6,7,8,9.
REQ-030 SHALL cover: EN dropped for 10 cycles at CNT=2 -> AN=1111, no SCAN_TICK, DIG_OUT held; after re-assertion slot ends after the 1 remaining cycle.
REQ-031 SHALL cover: RST_N=0 mid-slot -> next edge all outputs at REQ-022 values; first edge after release gives SCAN_TICK=1, DIG_OUT=digit 0.
REQ-032 SHALL cover: GUARD=0, REFRESH_DIV=2 -> AN never 1111 while EN=1; slot changes every 2 cycles.
